// File: rtl/move_rate_pkg.sv
// Shared constants and helpers for the move_rate_gen rate generator.
// DIV_MIN is the smallest divisor a channel can run with; hz_to_div turns
// a requested output rate into a divisor for a given clock frequency.
package move_rate_pkg;

  localparam int unsigned DIV_MIN    = 2;
  localparam int unsigned CLK_HZ_DEF = 100_000_000;
  localparam int unsigned DEF_HZ_DEF = 10;

  // Cycles per output period for the requested rate, never below DIV_MIN
  function automatic int unsigned hz_to_div(input int unsigned clk_hz,
                                            input int unsigned hz);
    int unsigned div;
    if (hz == 0) begin
      div = clk_hz;
    end else begin
      div = clk_hz / hz;
    end
    if (div < DIV_MIN) begin
      div = DIV_MIN;
    end
    return div;
  endfunction

endpackage

// File: rtl/rate_chan.sv
// One rate channel: free-running period counter with an active divisor and
// a single pending-divisor slot. A pending divisor is only swapped in at a
// period boundary (or immediately while the channel is stopped) so that a
// period never mixes two divisors. tick and level are registered.
module rate_chan import move_rate_pkg::*; #(
  parameter int unsigned      DIV_W   = 27,
  parameter logic [DIV_W-1:0] DEF_DIV = DIV_W'(10)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             pending,
  output logic             tick,
  output logic             level
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] load_clamped;
  logic [DIV_W:0]   half;
  logic             at_end;
  logic             wrap;
  logic             apply;

  assign load_clamped = (load_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : load_div;

  // ceil(div/2), one bit wider so div at full scale cannot overflow
  assign half   = ({1'b0, div} + (DIV_W+1)'(1)) >> 1;
  assign at_end = (cnt == div - DIV_W'(1));
  assign wrap   = en && at_end;
  assign apply  = pending && (!en || wrap || sync);

  // Period counter: held at 0 while stopped, restarts on wrap or sync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || wrap || sync) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  // Active divisor and pending slot; load only reaches here when the slot is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div      <= DEF_DIV;
      pend_div <= DEF_DIV;
      pending  <= 1'b0;
    end else if (apply) begin
      div     <= pend_div;
      pending <= 1'b0;
    end else if (load) begin
      pend_div <= load_clamped;
      pending  <= 1'b1;
    end
  end

  // Registered outputs derived from the counter state of the previous cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick  <= 1'b0;
      level <= 1'b0;
    end else begin
      tick  <= wrap && !sync;
      level <= en && ({1'b0, cnt} < half);
    end
  end

  a_cnt_in_range : assert property (@(posedge clk) disable iff (!rst_n) cnt < div);
  a_div_min      : assert property (@(posedge clk) disable iff (!rst_n) div >= DIV_W'(DIV_MIN));

endmodule

// File: rtl/move_rate_gen.sv
// move_rate_gen: CH independent programmable rate generators, each giving a
// one-cycle tick per period and a square-wave level. Divisors are loaded per
// channel through a valid/ready port; loads to channels that do not exist
// are accepted and dropped.
// Optional feature: define RATE_GEN_SYNC_EN to add the sync input, which
// restarts every enabled channel together (phase alignment).
module move_rate_gen import move_rate_pkg::*; #(
  parameter int unsigned CH     = 4,
  parameter int unsigned DIV_W  = 27,
  parameter int unsigned CLK_HZ = CLK_HZ_DEF,
  parameter int unsigned DEF_HZ = DEF_HZ_DEF
) (
  input  logic                                    Clk_In,
  input  logic                                    rst,
  input  logic [CH-1:0]                           ch_en,
  input  logic                                    cfg_valid,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0]  cfg_ch,
  input  logic [DIV_W-1:0]                        cfg_div,
`ifdef RATE_GEN_SYNC_EN
  input  logic                                    sync,
`endif
  output logic                                    cfg_ready,
  output logic [CH-1:0]                           tick,
  output logic [CH-1:0]                           level
);

  localparam int unsigned      CH_W    = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(hz_to_div(CLK_HZ, DEF_HZ));

  logic          sync_i;
  logic [CH-1:0] hit;
  logic [CH-1:0] load;
  logic [CH-1:0] pending;

`ifdef RATE_GEN_SYNC_EN
  assign sync_i = sync;
`else
  assign sync_i = 1'b0;
`endif

  // An out-of-range cfg_ch matches no channel, so it reads as ready and loads nothing
  assign cfg_ready = ~|(hit & pending);

  for (genvar g = 0; g < CH; g++) begin : g_chan
    assign hit[g]  = (cfg_ch == CH_W'(g));
    assign load[g] = cfg_valid && hit[g] && !pending[g];

    rate_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk      (Clk_In),
      .rst_n    (rst),
      .en       (ch_en[g]),
      .sync     (sync_i),
      .load     (load[g]),
      .load_div (cfg_div),
      .pending  (pending[g]),
      .tick     (tick[g]),
      .level    (level[g])
    );
  end

endmodule

// File: tb/tb_move_rate_gen.sv
// Bench for move_rate_gen with CLK_HZ=100, DEF_HZ=10 (default divisor 10),
// CH=4, DIV_W=8. Expected tick and level-edge events are queued with the
// cycle they must appear in; a negedge monitor pops and compares.
module tb_move_rate_gen;

  typedef enum int {EV_RISE, EV_FALL, EV_TICK} ev_kind_e;
  typedef struct {
    int       ch;
    int       cyc;
    ev_kind_e kind;
  } ev_t;

  logic       clk;
  logic       rst;
  logic [3:0] ch_en;
  logic       cfg_valid;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       sync;
  logic       cfg_ready;
  logic [3:0] tick;
  logic [3:0] level;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  logic mon_on      = 1'b0;
  logic [3:0] lvl_prev = '0;
  ev_t  exp_q[$];

  move_rate_gen #(
    .CH     (4),
    .DIV_W  (8),
    .CLK_HZ (100),
    .DEF_HZ (10)
  ) dut (
    .Clk_In    (clk),
    .rst       (rst),
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
`ifdef RATE_GEN_SYNC_EN
    .sync      (sync),
`endif
    .cfg_ready (cfg_ready),
    .tick      (tick),
    .level     (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int c, input int t, input ev_kind_e k);
    exp_q.push_back('{ch: c, cyc: t, kind: k});
  endtask

  // n full periods of divisor d on channel c whose counter is 0 in cycle t0
  task automatic push_periods(input int c, input int t0, input int d, input int n);
    int h;
    int b;
    h = (d + 1) / 2;
    for (int p = 0; p < n; p++) begin
      b = t0 + p * d;
      push_ev(c, b + 1, EV_RISE);
      push_ev(c, b + 1 + h, EV_FALL);
      push_ev(c, b + d, EV_TICK);
    end
  endtask

  task automatic check_ev(input int c, input ev_kind_e k);
    int idx;
    idx = -1;
    vectors++;
    foreach (exp_q[i]) begin
      if (idx < 0 && exp_q[i].ch == c) idx = i;
    end
    if (idx < 0) begin
      miscompares++;
      $display("FAIL ev_ch%0d: got %s at cycle %0d, required no event", c, k.name(), cyc);
    end else begin
      if (exp_q[idx].kind != k || exp_q[idx].cyc != cyc) begin
        miscompares++;
        $display("FAIL ev_ch%0d: got %s at cycle %0d, required %s at cycle %0d",
                 c, k.name(), cyc, exp_q[idx].kind.name(), exp_q[idx].cyc);
      end
      exp_q.delete(idx);
    end
  endtask

  // Monitor: every level edge and tick is an output event to be matched
  always @(negedge clk) begin
    if (mon_on) begin
      for (int c = 0; c < 4; c++) begin
        if (level[c] !== lvl_prev[c]) check_ev(c, (level[c] === 1'b1) ? EV_RISE : EV_FALL);
        if (tick[c] === 1'b1) check_ev(c, EV_TICK);
      end
      lvl_prev = level;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step(1);
  endtask

  initial begin
    int e;
    int x;
    rst       = 1'b1;
    ch_en     = '0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    sync      = 1'b0;
    #1 rst = 1'b0;
    step(2);
    chk("reset_tick", 32'(tick), 32'h0);
    chk("reset_level", 32'(level), 32'h0);
    chk("reset_ready", 32'(cfg_ready), 32'h1);
    rst    = 1'b1;
    mon_on = 1'b1;
    step(1);

    // Default divisor 10 on ch0 only
    e = cyc;
    ch_en = 4'b0001;
    push_periods(0, e, 10, 3);
    goto(e + 30);
    ch_en = '0;
    step(2);

    // Mid-period load of 7 on running ch1: old period completes first
    e = cyc;
    ch_en = 4'b0010;
    push_periods(1, e, 10, 1);
    push_periods(1, e + 10, 7, 2);
    goto(e + 3);
    cfg_ch = 2'd1; cfg_div = 8'd7; cfg_valid = 1'b1;
    #1 chk("load7_ready_before", 32'(cfg_ready), 32'h1);
    goto(e + 4);
    cfg_valid = 1'b0;
    #1 chk("load7_ready_pending", 32'(cfg_ready), 32'h0);
    goto(e + 9);
    chk("load7_ready_at_last", 32'(cfg_ready), 32'h0);
    goto(e + 10);
    chk("load7_ready_after_wrap", 32'(cfg_ready), 32'h1);
    goto(e + 24);
    ch_en = '0;
    step(2);

    // Divisor 0 and 1 clamp to 2; stopped channels apply at once
    x = cyc;
    cfg_ch = 2'd2; cfg_div = 8'd0; cfg_valid = 1'b1;
    #1 chk("clamp0_ready_before", 32'(cfg_ready), 32'h1);
    goto(x + 1);
    cfg_valid = 1'b0;
    #1 chk("clamp0_ready_pending", 32'(cfg_ready), 32'h0);
    goto(x + 2);
    chk("clamp0_ready_applied", 32'(cfg_ready), 32'h1);
    e = cyc;
    ch_en = 4'b0100;
    push_periods(2, e, 2, 3);
    goto(e + 6);
    ch_en = '0;
    step(2);
    x = cyc;
    cfg_ch = 2'd3; cfg_div = 8'd1; cfg_valid = 1'b1;
    goto(x + 1);
    cfg_valid = 1'b0;
    #1 chk("clamp1_ready_pending", 32'(cfg_ready), 32'h0);
    goto(x + 2);
    chk("clamp1_ready_applied", 32'(cfg_ready), 32'h1);
    e = cyc;
    ch_en = 4'b1000;
    push_periods(3, e, 2, 3);
    goto(e + 6);
    ch_en = '0;
    step(2);

    // Second load to a pending channel is refused; other channel accepted
    e = cyc;
    ch_en = 4'b0011;
    push_periods(0, e, 10, 1);
    push_periods(0, e + 10, 4, 3);
    push_periods(1, e, 7, 1);
    push_periods(1, e + 7, 5, 3);
    goto(e + 2);
    cfg_ch = 2'd0; cfg_div = 8'd4; cfg_valid = 1'b1;
    #1 chk("dbl_first_ready", 32'(cfg_ready), 32'h1);
    goto(e + 3);
    cfg_div = 8'd6;
    #1 chk("dbl_second_ready", 32'(cfg_ready), 32'h0);
    goto(e + 4);
    cfg_ch = 2'd1; cfg_div = 8'd5;
    #1 chk("dbl_other_ready", 32'(cfg_ready), 32'h1);
    goto(e + 5);
    cfg_valid = 1'b0;
    goto(e + 22);
    ch_en = '0;
    step(2);

    // Reset mid-period with a pending load on ch0 (divisor 4 at this point)
    e = cyc;
    ch_en = 4'b0001;
    push_ev(0, e + 1, EV_RISE);
    goto(e + 1);
    cfg_ch = 2'd0; cfg_div = 8'd3; cfg_valid = 1'b1;
    goto(e + 2);
    cfg_valid = 1'b0;
    #1 chk("rst_pend_ready", 32'(cfg_ready), 32'h0);
    push_ev(0, e + 2, EV_FALL);
    rst = 1'b0;
    #1;
    chk("rst_mid_tick", 32'(tick), 32'h0);
    chk("rst_mid_level", 32'(level), 32'h0);
    chk("rst_mid_ready", 32'(cfg_ready), 32'h1);
    goto(e + 4);
    rst = 1'b1;
    push_periods(0, e + 4, 10, 2);
    goto(e + 24);
    ch_en = '0;
    step(2);

`ifdef RATE_GEN_SYNC_EN
    // ch0 divisor 10, ch1 divisor 5 started 3 cycles later; sync aligns them
    x = cyc;
    cfg_ch = 2'd1; cfg_div = 8'd5; cfg_valid = 1'b1;
    goto(x + 1);
    cfg_valid = 1'b0;
    goto(x + 2);
    e = cyc;
    ch_en = 4'b0001;
    push_ev(0, e + 1, EV_RISE);
    goto(e + 3);
    ch_en = 4'b0011;
    push_ev(1, e + 4, EV_RISE);
    goto(e + 4);
    sync = 1'b1;
    goto(e + 5);
    sync = 1'b0;
    push_ev(0, e + 11, EV_FALL);
    push_ev(0, e + 15, EV_TICK);
    push_periods(0, e + 15, 10, 1);
    push_ev(1, e + 9, EV_FALL);
    push_ev(1, e + 10, EV_TICK);
    push_periods(1, e + 10, 5, 3);
    goto(e + 25);
    ch_en = '0;
    step(2);
`endif

    step(3);
    foreach (exp_q[i]) begin
      vectors++;
      miscompares++;
      $display("FAIL missing_ev_ch%0d: got nothing, required %s at cycle %0d",
               exp_q[i].ch, exp_q[i].kind.name(), exp_q[i].cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
